// File: rtl/arb8way16.sv
// arb8way16 - round-robin arbiter sharing one 16-bit valid/ready channel
// among eight requesters, with a bounded burst per grant.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   req[i] high: requester i presents a word on in_data[16i+15:16i]
//   in_data    eight packed 16-bit words
//   ack[7:0]   one-hot, high in the cycle requester i's word is accepted
//   grant[7:0] one-hot registered grant, all zero when idle
//   out_data   word of the selected requester (mux8way16 datapath)
//   out_valid  out_data carries a valid word
//   out_ready  consumer can accept a word
//   busy       high while a grant is active
//   dbg_state  current FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a word moves in exactly the cycle where out_valid && out_ready
// are both high; that same cycle raises ack[sel] towards the requester.
// out_valid never depends on out_ready, and while out_valid is high and
// out_ready is low the grant, select and out_data stay unchanged.

// mux8way16 - selects one 16-bit slice out of eight packed words.
//   in_data  eight packed words, word i at [16i+15:16i]
//   sel      index of the slice to forward
//   out_data selected word
module mux8way16 (
  input  logic [127:0] in_data,
  input  logic [2:0]   sel,
  output logic [15:0]  out_data
);
  assign out_data = in_data[{sel, 4'b0000} +: 16];
endmodule

module arb8way16 #(
  parameter int unsigned MAX_BURST = 4  // words per grant, 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [127:0] in_data,
  output logic [7:0]   ack,
  output logic [7:0]   grant,
  output logic [15:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [0:0]   dbg_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // cnt value of the final word of a burst
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [0:0] state;
  logic [2:0] sel;
  logic [2:0] last;
  logic [3:0] cnt;
  logic [2:0] next_sel;
  logic       xfer;

  // First requester found searching upward from (from + 1) with wrap-around.
  // Scanning from the far end down lets the nearest candidate win; offset 8
  // wraps to 'from' itself, so the released port only wins when it is alone.
  function automatic logic [2:0] rr_next(input logic [7:0] r,
                                         input logic [2:0] from);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = from;
    for (int k = 8; k >= 1; k--) begin
      idx = from + 3'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign next_sel = rr_next(req, last);

  assign busy      = (state == GRANT);
  assign dbg_state = state;
  assign grant     = busy ? (8'b0000_0001 << sel) : 8'h00;
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign ack       = xfer ? grant : 8'h00;

  mux8way16 u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (out_data)
  );

  // last resets to 7 so that port 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      last  <= 3'd7;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 8'h00) begin
            sel   <= next_sel;
            cnt   <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            // requester withdrew: release without a transfer
            last  <= sel;
            state <= IDLE;
          end else if (xfer) begin
            if (cnt == LAST_BEAT) begin
              last  <= sel;
              cnt   <= 4'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb8way16.sv
// tb_arb8way16 - directed and randomized bench for arb8way16.
// Two instances share the same inputs: dut0 with MAX_BURST=4, dut1 with
// MAX_BURST=1. A transaction-level model (owner / words-so-far / last
// released) predicts every output of both instances every cycle.
module tb_arb8way16;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [127:0] in_data;
  logic         out_ready;

  logic [7:0]  ack0, grant0, ack1, grant1;
  logic [15:0] data0, data1;
  logic        valid0, valid1, busy0, busy1;
  logic [0:0]  dbg0, dbg1;

  arb8way16 #(.MAX_BURST(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .ack(ack0),
    .grant(grant0), .out_data(data0), .out_valid(valid0),
    .out_ready(out_ready), .busy(busy0), .dbg_state(dbg0)
  );

  arb8way16 #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .ack(ack1),
    .grant(grant1), .out_data(data1), .out_valid(valid1),
    .out_ready(out_ready), .busy(busy1), .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ack0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner[2];   // granted port, -1 when idle
  int m_last[2];    // port most recently released
  int m_sel[2];     // port whose word is on out_data
  int m_words[2];   // words accepted in the current grant
  int m_burst[2] = '{4, 1};

  function automatic int rr_pick(input int from, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = 7; m_sel[d] = 0; m_words[d] = 0;
    end
  endtask

  task automatic model_check(input int d, input logic [7:0] g,
                             input logic [7:0] a, input logic [15:0] od,
                             input logic ov, input logic b,
                             input logic [0:0] st);
    logic [7:0]  eg, ea;
    logic [15:0] ed;
    logic        ev, eb;
    eg = 8'h00; ea = 8'h00; ev = 1'b0; eb = 1'b0;
    ed = in_data[16*m_sel[d] +: 16];
    if (m_owner[d] >= 0) begin
      eg = 8'(1 << m_owner[d]);
      ev = req[m_owner[d]];
      ea = (ev && out_ready) ? eg : 8'h00;
      eb = 1'b1;
    end
    if (d == 0) exp_ack0 = ea;
    chk($sformatf("d%0d_grant", d), g, eg);
    chk($sformatf("d%0d_ack", d), a, ea);
    chk($sformatf("d%0d_valid", d), ov, ev);
    chk($sformatf("d%0d_data", d), od, ed);
    chk($sformatf("d%0d_busy", d), b, eb);
    chk($sformatf("d%0d_state", d), st, eb);
  endtask

  task automatic model_step(input int d);
    int p;
    if (m_owner[d] < 0) begin
      p = rr_pick(m_last[d], req);
      if (p >= 0) begin
        m_owner[d] = p; m_sel[d] = p; m_words[d] = 0;
      end
    end else if (!req[m_owner[d]]) begin
      m_last[d] = m_owner[d]; m_owner[d] = -1;
    end else if (out_ready) begin
      m_words[d]++;
      if (m_words[d] == m_burst[d]) begin
        m_last[d] = m_owner[d]; m_owner[d] = -1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // settle: inputs were driven at the falling edge; check just after it.
  task automatic settle();
    #1;
    model_check(0, grant0, ack0, data0, valid0, busy0, dbg0);
    model_check(1, grant1, ack1, data1, valid1, busy1, dbg1);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    settle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int idx_of(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] prev_g;
    int acks;
    int seq[$];

    rst_n = 1'b0; req = 8'h00; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // 1: single requester, full burst of four
    apply_reset();
    req = 8'h01; in_data[15:0] = 16'hAAAA; out_ready = 1'b1;
    tick();
    settle();
    chk("t1_grant", grant0, 8'h01);
    chk("t1_data", data0, 16'hAAAA);
    advance();
    for (int i = 0; i < 8; i++) tick();

    // 2: all requesting, rotation 0..7,0 with 4 acks each
    apply_reset();
    for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'(16'h1111 * i);
    req = 8'hFF; out_ready = 1'b1;
    prev_g = 8'h00; acks = 0; seq.delete();
    for (int c = 0; c < 46; c++) begin
      settle();
      if (grant0 != 8'h00 && prev_g == 8'h00) seq.push_back(idx_of(grant0));
      if (ack0 != 8'h00) acks++;
      prev_g = grant0;
      advance();
    end
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(i % 8));
    chk("t2_ngrants", seq.size(), exp_q.size());
    for (int i = 0; i < seq.size() && i < exp_q.size(); i++)
      chk($sformatf("t2_order%0d", i), seq[i], exp_q[i]);
    chk("t2_acks", acks, 36);

    // 3: port 2 stalled by out_ready=0
    apply_reset();
    req = 8'h04; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t3_grant", grant0, 8'h04);
      chk("t3_valid", valid0, 1'b1);
      chk("t3_data", data0, 16'h2222);
      chk("t3_ack", ack0, 8'h00);
      advance();
    end
    out_ready = 1'b1;
    settle();
    chk("t3_ack_go", ack0, 8'h04);
    advance();
    req = 8'h00;
    for (int i = 0; i < 6; i++) tick();

    // 4: port 5 withdraws after one word; port 1 is next
    apply_reset();
    req = 8'h20; out_ready = 1'b1;
    tick();
    tick();
    req = 8'h02;
    settle();
    chk("t4_noack", ack0, 8'h00);
    advance();
    settle();
    chk("t4_idle", busy0, 1'b0);
    advance();
    settle();
    chk("t4_next", grant0, 8'h02);
    advance();
    req = 8'h00;
    for (int i = 0; i < 6; i++) tick();

    // 5: asynchronous reset mid-burst on port 3
    apply_reset();
    req = 8'h08; out_ready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", grant0, 8'h00);
    chk("t5_valid", valid0, 1'b0);
    chk("t5_ack", ack0, 8'h00);
    model_reset();
    @(negedge clk);
    req = 8'h88; in_data[127:112] = 16'h7777;
    settle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    settle();
    chk("t5_first", grant0, 8'h08);
    advance();
    for (int i = 0; i < 12; i++) tick();

    // 6: dut1 (MAX_BURST=1) alternates 0,7,0,7
    apply_reset();
    req = 8'h81; out_ready = 1'b1;
    prev_g = 8'h00; seq.delete();
    for (int c = 0; c < 8; c++) begin
      settle();
      if (grant1 != 8'h00 && prev_g == 8'h00) seq.push_back(idx_of(grant1));
      prev_g = grant1;
      advance();
    end
    exp_q.delete();
    exp_q.push_back(8'd0); exp_q.push_back(8'd7);
    exp_q.push_back(8'd0); exp_q.push_back(8'd7);
    chk("t6_ngrants", seq.size(), exp_q.size());
    for (int i = 0; i < seq.size() && i < exp_q.size(); i++)
      chk($sformatf("t6_order%0d", i), seq[i], exp_q[i]);

    // 7: randomized traffic; data only changes while req is low
    apply_reset();
    req = 8'h00;
    for (int c = 0; c < 400; c++) begin
      settle();
      advance();
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (exp_ack0[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
          else if (!exp_ack0[i] && $urandom_range(0, 40) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          in_data[16*i +: 16] = 16'($urandom);
          req[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb8way16.md
Name: arb8way16

Overview:
- Round-robin arbiter that shares one 16-bit output channel among 8 requesters.
- Instantiates mux8way16 as its datapath and drives the mux select from a registered grant index.
- Sits between eight word producers (e.g. CPU, DMA, debug ports) and a single consumer that uses a valid/ready handshake.
- Each granted requester may transfer a bounded burst of words before the grant rotates.

Parameters:
- MAX_BURST, 4, maximum words transferred per grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  req[i] high: requester i has a word on its data slice.
- in_data  input  128  packed words; requester i drives bits [16i+15:16i].
- ack  output  8  one-hot; ack[i] high in the cycle requester i's word is accepted.
- grant  output  8  one-hot registered grant; all zero when idle.
- out_data  output  16  selected word, mux8way16(in_data slices, sel).
- out_valid  output  1  word on out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid is also high.
- busy  output  1  high in state GRANT.

Behaviour:
- Internal registers:
  - state: IDLE or GRANT.
  - sel[2:0]: index of the granted requester.
  - last[2:0]: index of the most recently released requester.
  - cnt[3:0]: words transferred in the current grant.
- Reset (async, rst_n=0): state=IDLE, sel=0, last=7, cnt=0. Outputs: grant=0, out_valid=0, ack=0, busy=0. out_data = in_data[15:0] (sel=0). Port 0 has first priority after reset.
- Reset asserted mid-burst: the grant drops immediately, with no ack and no out_valid. After release, arbitration restarts from port 0.
- IDLE:
  - grant=0, out_valid=0, ack=0.
  - If req != 0, search upward from (last+1) mod 8 with wrap-around. Load the first requester found into sel, set cnt=0, go to GRANT.
  - Arbitration latency is exactly one cycle from req seen to grant high.
- GRANT:
  - grant = onehot(sel).
  - out_valid = req[sel]; out_data = in_data slice sel.
  - ack[sel] = out_valid & out_ready; all other ack bits are 0.
  - Transfer (out_valid & out_ready) with cnt == MAX_BURST-1: last<=sel, cnt<=0, state<=IDLE.
  - Transfer with cnt < MAX_BURST-1: cnt<=cnt+1; stay in GRANT. The next word from the same requester may be accepted the next cycle.
  - req[sel]==0 (requester withdrew): last<=sel, state<=IDLE, no transfer, no ack.
  - out_valid=1, out_ready=0: hold state. out_data must remain stable.
- Requester rules:
  - Hold req and its data slice stable until ack.
  - Changing data while req=1 and ack=0 is a protocol violation; the arbiter behaviour is then unspecified.
- Requests from non-granted ports are ignored until the next IDLE cycle. No request is lost, because req is level-based.
- Every grant ends with at least one IDLE cycle. Worst-case wait for any requester is 7*(MAX_BURST+1)+1 cycles when out_ready is held high.
- MAX_BURST=1: every accepted word returns to IDLE.
- Simultaneous requests: only the round-robin order decides; no port has fixed priority beyond the reset value of last.

Test Plan:
1. Reset, then req=8'h01, in_data[15:0]=16'hAAAA, out_ready=1 -> grant=8'h01 one cycle after req. out_valid=1, out_data=16'hAAAA. ack[0] pulses 4 times (MAX_BURST=4), then the block returns to IDLE.
2. req=8'hFF, each slice i = 16'h1111*i, out_ready=1 -> grants go to ports 0,1,2,...,7,0 in order. out_data matches each slice. Each grant has 4 acks, separated by one idle cycle.
3. Port 2 granted, out_ready=0 for 5 cycles -> grant=8'h04, out_valid=1, out_data stable at 16'h2222, ack=0, cnt unchanged. On out_ready=1, ack[2] pulses.
4. Port 5 granted after one transfer, then req[5] dropped -> the next cycle is IDLE, busy=0, no ack. Next grant goes to port 6 if requesting, otherwise to the lowest wrapped requester (e.g. port 1).
5. rst_n pulled low mid-burst on port 3 -> grant=0, out_valid=0, ack=0 asynchronously. After release with req=8'h88, port 3 is granted before port 7 (last=7).
6. MAX_BURST=1, req=8'h81, out_ready=1 -> grants alternate 0,7,0,7, with one ack per grant and one IDLE cycle between grants.
